// File: rtl/servo_pwm_pkg.sv
// Shared constants and the duty clamp helper for the servo PWM bank.
package servo_pwm_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_COUNT_WIDTH  = 12;
    localparam int DEF_PERIOD_TICKS = 4000;
    localparam int DEF_TICK_DIV     = 250;
    localparam int DEF_MIN_PULSE    = 200;
    localparam int DEF_MAX_PULSE    = 400;
    localparam int CH_IDX_WIDTH     = 5;

    // Saturates a requested pulse width into the legal servo window.
    function automatic logic [31:0] clamp_duty(
        input logic [31:0] value,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [31:0] res;
        if (value < lo) begin
            res = lo;
        end else if (value > hi) begin
            res = hi;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: double-buffered duty (pending/active) and registered compare output.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int MAX_PULSE   = DEF_MAX_PULSE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_sel,
    input  logic [COUNT_WIDTH-1:0] wr_value,
    input  logic                   boundary,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   pwm
);

    logic [COUNT_WIDTH-1:0] clamped_s;
    logic [COUNT_WIDTH-1:0] pending_r;
    logic                   valid_r;
    logic [COUNT_WIDTH-1:0] active_r;
    logic                   pwm_r;

    assign clamped_s = COUNT_WIDTH'(clamp_duty(32'(wr_value), 32'(MIN_PULSE), 32'(MAX_PULSE)));
    assign pwm       = pwm_r;

    // Pending capture; a write in the boundary cycle re-arms valid for the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {COUNT_WIDTH{1'b0}};
            valid_r   <= 1'b0;
        end else if (wr_sel) begin
            pending_r <= clamped_s;
            valid_r   <= 1'b1;
        end else if (boundary) begin
            pending_r <= pending_r;
            valid_r   <= 1'b0;
        end else begin
            pending_r <= pending_r;
            valid_r   <= valid_r;
        end
    end

    // Active duty only changes on a period boundary so a pulse is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= {COUNT_WIDTH{1'b0}};
        end else if (boundary && valid_r) begin
            active_r <= pending_r;
        end else begin
            active_r <= active_r;
        end
    end

    // Registered compare output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= enable && (count < active_r);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of servo PWM channels sharing one prescaler, period counter and write decoder.
module servo_pwm_bank
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int MIN_PULSE    = DEF_MIN_PULSE,
    parameter int MAX_PULSE    = DEF_MAX_PULSE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [CH_IDX_WIDTH-1:0] wr_channel,
    input  logic [COUNT_WIDTH-1:0]  wr_value,
    input  logic [NUM_CHANNELS-1:0] ch_enable,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic                    period_start,
    output logic                    wr_error
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]      PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [COUNT_WIDTH-1:0]  COUNT_LAST = COUNT_WIDTH'(PERIOD_TICKS - 1);
    localparam logic [CH_IDX_WIDTH:0]   NUM_CH_EXT = (CH_IDX_WIDTH + 1)'(NUM_CHANNELS);

    logic [PRESC_W-1:0]      presc_r;
    logic [COUNT_WIDTH-1:0]  count_r;
    logic                    tick_s;
    logic                    boundary_s;
    logic                    ch_ok_s;
    logic                    period_start_r;
    logic                    wr_error_r;
    logic [NUM_CHANNELS-1:0] wr_sel_s;

    assign tick_s       = (presc_r == PRESC_LAST);
    assign boundary_s   = tick_s && (count_r == COUNT_LAST);
    assign ch_ok_s      = ({1'b0, wr_channel} < NUM_CH_EXT);
    assign period_start = period_start_r;
    assign wr_error     = wr_error_r;

    // Tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRESC_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRESC_W'(1'b1);
        end
    end

    // Period counter, advancing once per tick and wrapping only at the period end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (boundary_s) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (tick_s) begin
            count_r <= count_r + COUNT_WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Status pulses, each valid for the single cycle after its cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start_r <= 1'b0;
            wr_error_r     <= 1'b0;
        end else begin
            period_start_r <= boundary_s;
            wr_error_r     <= wr_en && !ch_ok_s;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign wr_sel_s[i] = wr_en && (wr_channel == CH_IDX_WIDTH'(i));

        servo_pwm_channel #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .MIN_PULSE   (MIN_PULSE),
            .MAX_PULSE   (MAX_PULSE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_sel   (wr_sel_s[i]),
            .wr_value (wr_value),
            .boundary (boundary_s),
            .enable   (ch_enable[i]),
            .count    (count_r),
            .pwm      (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: table of duty writes plus hand-written corner sequences.
module tb_servo_pwm_bank;

    localparam int NC = 2;
    localparam int CW = 8;
    localparam int PT = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_channel = 5'd0;
    logic [CW-1:0] wr_value = 8'd0;
    logic [NC-1:0] ch_enable = 2'b00;
    logic [NC-1:0] pwm_out;
    logic          period_start;
    logic          wr_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_act [NC];

    typedef struct {
        int ch;
        int value;
        int exp_active;
    } wr_vec_t;

    wr_vec_t vecs [8];

    servo_pwm_bank #(
        .NUM_CHANNELS (NC),
        .COUNT_WIDTH  (CW),
        .PERIOD_TICKS (PT),
        .TICK_DIV     (1),
        .MIN_PULSE    (3),
        .MAX_PULSE    (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_channel   (wr_channel),
        .wr_value     (wr_value),
        .ch_enable    (ch_enable),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .wr_error     (wr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; cyc counts edges since reset release, so DUT count == cyc % PT afterwards.
    task automatic tick_cycle();
        bit e;
        e = wr_en && (wr_channel >= 5'd2);
        @(posedge clk);
        #1;
        cyc++;
        check("period_start", int'(period_start), int'((cyc % PT) == 0));
        check("wr_error", int'(wr_error), int'(e));
    endtask

    task automatic wait_count(input int k);
        for (int n = 0; n < 2 * PT && (cyc % PT) != k; n++) tick_cycle();
    endtask

    task automatic do_write(input int ch, input int val);
        wr_en      = 1'b1;
        wr_channel = 5'(ch);
        wr_value   = 8'(val);
        tick_cycle();
        wr_en      = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check(name, int'({pwm_out, period_start, wr_error}), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        check_idle("reset_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_idle("reset_hold");
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Measure one full period starting at a boundary; sample j reflects count j.
    task automatic measure(input int e0, input int e1);
        int w [NC];
        int bad [NC];
        int ex [NC];
        ex[0] = e0;
        ex[1] = e1;
        for (int c = 0; c < NC; c++) begin
            w[c]   = 0;
            bad[c] = 0;
        end
        for (int n = 0; n < 2 * PT && (cyc % PT) != 0; n++) tick_cycle();
        for (int j = 0; j < PT; j++) begin
            tick_cycle();
            for (int c = 0; c < NC; c++) begin
                w[c] += int'(pwm_out[c]);
                if (int'(pwm_out[c]) != int'(j < ex[c])) bad[c]++;
            end
        end
        check("width_ch0", w[0], e0);
        check("width_ch1", w[1], e1);
        check("shape_ch0", bad[0], 0);
        check("shape_ch1", bad[1], 0);
    endtask

    initial begin
        int hi;
        int bad;

        vecs[0] = '{ch: 1, value: 1,   exp_active: 3};
        vecs[1] = '{ch: 1, value: 30,  exp_active: 15};
        vecs[2] = '{ch: 0, value: 0,   exp_active: 3};
        vecs[3] = '{ch: 0, value: 15,  exp_active: 15};
        vecs[4] = '{ch: 1, value: 255, exp_active: 15};
        vecs[5] = '{ch: 0, value: 3,   exp_active: 3};
        vecs[6] = '{ch: 1, value: 14,  exp_active: 14};
        vecs[7] = '{ch: 0, value: 10,  exp_active: 10};

        ch_enable = 2'b11;
        #2;
        apply_reset();

        // Write ch0=5 at count 7: no pulse before the boundary, then 5 of every 20.
        wait_count(7);
        do_write(0, 5);
        hi = 0;
        for (int n = 0; n < 2 * PT && (cyc % PT) != 0; n++) begin
            tick_cycle();
            hi += int'(pwm_out[0]);
        end
        check("pre_boundary_low", hi, 0);
        exp_act[0] = 5;
        exp_act[1] = 0;
        measure(exp_act[0], exp_act[1]);
        measure(exp_act[0], exp_act[1]);

        for (int v = 0; v < 8; v++) begin
            wait_count(7);
            do_write(vecs[v].ch, vecs[v].value);
            exp_act[vecs[v].ch] = vecs[v].exp_active;
            measure(exp_act[0], exp_act[1]);
        end

        // Back-to-back writes in one period: the later one wins.
        wait_count(5);
        do_write(1, 4);
        do_write(1, 9);
        exp_act[1] = 9;
        measure(exp_act[0], exp_act[1]);

        // Write landing in the boundary cycle while 6 is pending.
        wait_count(7);
        do_write(0, 6);
        wait_count(19);
        do_write(0, 8);
        measure(6, exp_act[1]);
        exp_act[0] = 8;
        measure(exp_act[0], exp_act[1]);

        // Out-of-range channels are rejected without touching any channel.
        wait_count(7);
        do_write(2, 9);
        tick_cycle();
        do_write(31, 100);
        measure(exp_act[0], exp_act[1]);

        // Enable gap on ch1 with active=10.
        wait_count(7);
        do_write(1, 10);
        exp_act[1] = 10;
        measure(exp_act[0], exp_act[1]);
        bad = 0;
        hi  = 0;
        for (int j = 0; j < PT; j++) begin
            ch_enable[1] = !((cyc % PT) == 1 || (cyc % PT) == 2);
            tick_cycle();
            hi += int'(pwm_out[1]);
            if (int'(pwm_out[1]) != int'((j < 10) && !(j == 1 || j == 2))) bad++;
        end
        ch_enable = 2'b11;
        check("enable_gap_shape", bad, 0);
        check("enable_gap_width", hi, 8);

        // Reset mid-pulse with a write still pending.
        wait_count(1);
        do_write(0, 12);
        check("pulse_before_reset", int'(pwm_out[0]), 1);
        apply_reset();
        hi = 0;
        for (int n = 0; n < 45; n++) begin
            tick_cycle();
            hi += int'(pwm_out[0]) + int'(pwm_out[1]);
        end
        check("post_reset_low", hi, 0);
        wait_count(7);
        do_write(0, 7);
        measure(7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_bank.md
SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent servo PWM outputs, range 1..32.
REQ-002 Parameter COUNT_WIDTH, default 12: width of period counter and duty values.
REQ-003 Parameter PERIOD_TICKS, default 4000: ticks per PWM period, 2..2^COUNT_WIDTH.
REQ-004 Parameter TICK_DIV, default 250: CLOCK cycles per tick, ≥1.
REQ-005 Parameters MIN_PULSE, default 200, and MAX_PULSE, default 400: duty clamp limits in ticks, MIN_PULSE ≤ MAX_PULSE < PERIOD_TICKS.
REQ-006 CLOCK  in  1  single system clock; all state on rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 WR_EN  in  1  duty write strobe, one write per asserted cycle.
REQ-009 WR_CHANNEL  in  5  target channel index.
REQ-010 WR_VALUE  in  COUNT_WIDTH  requested pulse width in ticks.
REQ-011 CH_ENABLE  in  NUM_CHANNELS  per-channel output enable.
REQ-012 PWM_OUT  out  NUM_CHANNELS  registered servo pulse outputs.
REQ-013 PERIOD_START  out  1  one-cycle pulse on each period boundary.
REQ-014 WR_ERROR  out  1  one-cycle pulse when a write is rejected.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 and asserts internal tick in the cycle it holds TICK_DIV-1; TICK_DIV=1 gives a tick every cycle.
REQ-016 Period counter COUNT advances by 1 on each tick and wraps from PERIOD_TICKS-1 to 0; no other wrap value.
REQ-017 Boundary cycle: tick asserted with COUNT == PERIOD_TICKS-1; PERIOD_START is high in the cycle after the boundary edge.
REQ-018 Each channel has a pending register, a pending-valid flag and an active register.
REQ-019 Accepted write: WR_EN=1 and WR_CHANNEL < NUM_CHANNELS; pending <= clamp(WR_VALUE) to [MIN_PULSE, MAX_PULSE]; pending-valid <= 1.
REQ-020 Write with WR_CHANNEL ≥ NUM_CHANNELS is ignored; WR_ERROR is high for the following cycle only.
REQ-021 At the boundary edge, every channel with pending-valid=1 copies pending to active and clears pending-valid; active never changes mid-period.
REQ-022 A write coinciding with the boundary cycle: the old pending value transfers to active, the new value is stored and pending-valid stays 1 for the next boundary.
REQ-023 Repeated writes within one period: last write wins; earlier values are discarded.
REQ-024 PWM_OUT[i] <= CH_ENABLE[i] && (COUNT < active[i]), registered; one-cycle latency from COUNT.
REQ-025 Pulse width is exactly active[i] ticks per period; an active value of 0 gives a constant-low output.
REQ-026 Deasserting CH_ENABLE[i] forces PWM_OUT[i] low on the next edge; re-enabling resumes mid-period without restarting the counter.

Reset
REQ-027 RESET_N low asynchronously clears the prescaler, COUNT, all active and pending registers, and all pending-valid flags.
REQ-028 During and after reset, PWM_OUT, PERIOD_START and WR_ERROR are 0.
REQ-029 After reset release, the first tick occurs TICK_DIV cycles later.
REQ-030 Reset asserted mid-pulse drops PWM_OUT immediately; pending writes are lost.

Structure
REQ-031 Package servo_pwm_pkg holds default parameter constants, the channel-index width constant and the clamp function.
REQ-032 Sub-module servo_pwm_channel holds the pending, valid and active registers, the compare logic and the output register; it is instantiated NUM_CHANNELS times by a generate loop.
REQ-033 The prescaler, period counter and write decode are shared in the top level.

Verification (bench parameters: NUM_CHANNELS=2, COUNT_WIDTH=8, PERIOD_TICKS=20, TICK_DIV=1, MIN_PULSE=3, MAX_PULSE=15)
REQ-034 Write ch0=5 at COUNT=7 with CH_ENABLE=11 -> PWM_OUT[0] stays low until the boundary, then is high for exactly 5 cycles of every 20; PERIOD_START pulses every 20 cycles.
REQ-035 Write ch1=1, then ch1=30 -> active values are 3 and 15 respectively (clamped); measured pulse widths are 3 and 15 cycles.
REQ-036 Write ch0=8 in the boundary cycle while pending=6 -> next period width is 6, the following period width is 8.
REQ-037 Write with WR_CHANNEL=2 -> WR_ERROR is high for exactly one cycle; no channel changes.
REQ-038 Assert RESET_N=0 at COUNT=2 during a pulse -> PWM_OUT drops to 0 without waiting for a clock edge; after release, all outputs stay low until a new write and boundary occur.
REQ-039 Toggle CH_ENABLE[1] low at COUNT=1 and high at COUNT=3 with active=10 -> PWM_OUT[1] is low for those cycles, then high until COUNT reaches 10.
